// File: rtl/mem_pkg.sv
// mem_pkg: load/store size codes and data-memory FSM states shared with the control unit.
package mem_pkg;
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LBU = 3'b001;
  localparam logic [2:0] LOAD_LH  = 3'b010;
  localparam logic [2:0] LOAD_LHU = 3'b011;
  localparam logic [2:0] LOAD_LW  = 3'b100;
  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word array with per-byte write enables and a registered read.
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      dout <= mem[addr];
    end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle load/store responder with lane steering, extension and alignment checks.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [2:0]  Load,
  input  logic [1:0]  Store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign
);
  state_t state;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q, rdata_q, din, dout, resp_data;
  logic [2:0] load_q;
  logic [1:0] store_q;
  logic [3:0] cnt, we;
  logic [15:0] h;
  logic [7:0] b;
  logic wr_q, mis_q, mis;
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];
  always_comb
    mis = mWR ? (Store == STORE_SB ? 1'b0 : Store == STORE_SH ? addr[0] : |addr[1:0])
              : (Load == LOAD_LB || Load == LOAD_LBU) ? 1'b0
              : (Load == LOAD_LH || Load == LOAD_LHU) ? addr[0] : |addr[1:0];
  always_ff @(posedge clk)
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else
      case (state)
        S_IDLE:
          if (mRD || mWR) begin
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            load_q  <= Load;
            store_q <= Store;
            wr_q    <= mWR;
            mis_q   <= mis;
            cnt     <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
            state   <= WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS;
          end
        S_WAIT:
          if (cnt == 4'd0) state <= S_ACCESS;
          else cnt <= cnt - 4'd1;
        S_ACCESS: state <= S_RESP;
        default: begin
          rdata_q <= resp_data;
          state   <= S_IDLE;
        end
      endcase
  // rst gates the write so a reset landing on the ACCESS edge discards it
  always_comb begin
    we = !(state == S_ACCESS && wr_q && !mis_q && !rst) ? 4'b0000
       : store_q == STORE_SB ? 4'b0001 << addr_q[1:0]
       : store_q == STORE_SH ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    din = store_q == STORE_SB ? {4{wdata_q[7:0]}}
        : store_q == STORE_SH ? {2{wdata_q[15:0]}} : wdata_q;
  end
  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk (clk),
    .en  (state == S_ACCESS),
    .we  (we),
    .addr(addr_q[ADDR_W+1:2]),
    .din (din),
    .dout(dout)
  );
  always_comb begin
    h = addr_q[1] ? dout[31:16] : dout[15:0];
    b = addr_q[0] ? h[15:8] : h[7:0];
    resp_data = mis_q ? 32'd0 : wr_q ? rdata_q
              : load_q == LOAD_LB  ? {{24{b[7]}}, b}
              : load_q == LOAD_LBU ? {24'd0, b}
              : load_q == LOAD_LH  ? {{16{h[15]}}, h}
              : load_q == LOAD_LHU ? {16'd0, h} : dout;
  end
  assign ready    = state == S_RESP;
  assign misalign = ready && mis_q;
  assign busy     = state != S_IDLE;
  assign rdata    = ready ? resp_data : rdata_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed scoreboard bench for data_mem_unit with 0 and 3 wait states.
module tb_data_mem_unit;
  import mem_pkg::*;
  logic clk = 0, rst = 1;
  logic [1:0] mrd = 0, mwr = 0, rdy, bsy, mis;
  logic [2:0] ld [2];
  logic [1:0] st [2];
  logic [31:0] ad [2], wd [2], rd [2], last [2];
  logic [32:0] q0 [$], q1 [$];
  int checks = 0, failures = 0;
  int rcnt [2] = '{0, 0};
  always #5 clk = ~clk;
  data_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst(rst), .mRD(mrd[0]), .mWR(mwr[0]), .Load(ld[0]), .Store(st[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]), .busy(bsy[0]), .misalign(mis[0]));
  data_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(3)) d3 (
    .clk(clk), .rst(rst), .mRD(mrd[1]), .mWR(mwr[1]), .Load(ld[1]), .Store(st[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]), .busy(bsy[1]), .misalign(mis[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: every ready pops one expected {misalign, rdata}
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      logic [32:0] e;
      if (rdy[k]) begin
        rcnt[k]++;
        if ((k == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_ready", 32'd1, 32'd0);
        else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk(k == 0 ? "rdata_w0" : "rdata_w3", rd[k], e[31:0]);
          chk(k == 0 ? "misalign_w0" : "misalign_w3", {31'd0, mis[k]}, {31'd0, e[32]});
        end
      end else if (mis[k]) chk("misalign_without_ready", 32'd1, 32'd0);
    end
  task automatic req(input int k, input bit wr, input logic [2:0] l, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] w, input logic [31:0] expd,
                     input bit expmis, input int pulse_at);
    logic [31:0] e;
    int n;
    e = wr ? (expmis ? 32'd0 : last[k]) : expd;
    last[k] = e;
    if (k == 0) q0.push_back({expmis, e});
    else q1.push_back({expmis, e});
    @(negedge clk);
    mrd[k] = !wr; mwr[k] = wr; ld[k] = l; st[k] = s; ad[k] = a; wd[k] = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      mwr[k] = 1'b0;
      mrd[k] = (n == pulse_at);
      if (k == 1) chk("busy_during_w3", {31'd0, bsy[k]}, 32'd1);
    end while (!rdy[k] && n < 20);
    mrd[k] = 1'b0;
    chk("latency", n, k == 0 ? 32'd2 : 32'd5);
    @(negedge clk);
    chk("busy_after_ready", {31'd0, bsy[k]}, 32'd0);
  endtask
  initial begin
    int c;
    for (int k = 0; k < 2; k++) begin
      ld[k] = LOAD_LW; st[k] = STORE_SW; ad[k] = 0; wd[k] = 0; last[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", rd[k], 32'd0);
      chk("reset_ready", {31'd0, rdy[k]}, 32'd0);
      chk("reset_busy", {31'd0, bsy[k]}, 32'd0);
      chk("reset_misalign", {31'd0, mis[k]}, 32'd0);
    end
    req(0, 1, LOAD_LW,  STORE_SW, 32'h10,  32'hDEADBEEF, 0, 0, 0);
    req(0, 0, LOAD_LW,  STORE_SW, 32'h10,  0, 32'hDEADBEEF, 0, 0);
    req(0, 0, LOAD_LB,  STORE_SW, 32'h13,  0, 32'hFFFFFFDE, 0, 0);
    req(0, 0, LOAD_LBU, STORE_SW, 32'h13,  0, 32'h000000DE, 0, 0);
    req(0, 0, LOAD_LH,  STORE_SW, 32'h12,  0, 32'hFFFFDEAD, 0, 0);
    req(0, 0, LOAD_LHU, STORE_SW, 32'h10,  0, 32'h0000BEEF, 0, 0);
    req(0, 0, LOAD_LB,  STORE_SW, 32'h10,  0, 32'hFFFFFFEF, 0, 0);
    req(0, 0, LOAD_LW,  STORE_SW, 32'h410, 0, 32'hDEADBEEF, 0, 0);
    req(0, 1, LOAD_LW,  STORE_SW, 32'h20,  32'h0, 0, 0, 0);
    req(0, 1, LOAD_LW,  STORE_SB, 32'h21,  32'h777777AB, 0, 0, 0);
    req(0, 1, LOAD_LW,  STORE_SH, 32'h22,  32'h99991234, 0, 0, 0);
    req(0, 0, LOAD_LW,  STORE_SW, 32'h20,  0, 32'h1234AB00, 0, 0);
    req(0, 0, LOAD_LW,  STORE_SW, 32'h12,  0, 32'h0, 1, 0);
    req(0, 1, LOAD_LW,  STORE_SH, 32'h21,  32'h0000FFFF, 0, 1, 0);
    req(0, 0, LOAD_LW,  STORE_SW, 32'h20,  0, 32'h1234AB00, 0, 0);
    req(0, 0, 3'b111,   STORE_SW, 32'h10,  0, 32'hDEADBEEF, 0, 0);
    req(1, 1, LOAD_LW,  STORE_SW, 32'h30,  32'h11223344, 0, 0, 0);
    c = rcnt[1];
    req(1, 0, LOAD_LW,  STORE_SW, 32'h30,  0, 32'h11223344, 0, 2);
    repeat (8) @(negedge clk);
    chk("ignored_mrd_single_ready", rcnt[1], c + 1);
    c = rcnt[1];
    @(negedge clk);
    mwr[1] = 1; st[1] = STORE_SW; ad[1] = 32'h30; wd[1] = 32'h55;
    @(negedge clk);
    mwr[1] = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    last[0] = 0; last[1] = 0;
    chk("rst_mid_rdata", rd[1], 32'd0);
    chk("rst_mid_ready", {31'd0, rdy[1]}, 32'd0);
    chk("rst_mid_busy", {31'd0, bsy[1]}, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_mid_no_ready", rcnt[1], c);
    req(1, 0, LOAD_LW, STORE_SW, 32'h30, 0, 32'h11223344, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-memory responder for the multi-cycle MIPS CPU: services the load/store requests the control unit issues in its memory states (mRD/mWR strobes with Load/Store size codes), performs byte-lane steering, sign/zero extension and alignment checking, and returns read data with a ready pulse after a configurable number of wait states. It sits between the ALU address output and the write-back data path (DBDataSrc = 1 selects rdata).

## Interface
- ADDR_W, 8: word-address bits; capacity 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 0: extra cycles inserted between request acceptance and array access (0..15).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mRD  in  1  load request strobe; sampled in IDLE.
- mWR  in  1  store request strobe; sampled in IDLE.
- Load  in  3  load type: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw; others are treated as lw.
- Store  in  2  store type: 00 sb, 01 sh, 10 sw; 11 is treated as sw.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data from rt; the low byte/half/word is used.
- rdata  out  32  extended load result; holds until the next completed load.
- ready  out  1  one-cycle completion pulse for every accepted request.
- busy  out  1  high from the cycle after acceptance until the cycle after ready.
- misalign  out  1  high with ready when the request was rejected for alignment.

## Operation
- Little-endian. Byte lane = addr[1:0]; byte 0 = bits 7:0. Word index = addr[ADDR_W+1:2]; the upper address bits are ignored, so addresses wrap.
- States: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on mRD or mWR, latch addr, wdata, Load, Store and the request type. Go to WAIT if WAIT_CYCLES > 0, else ACCESS.
  - WAIT: count down from WAIT_CYCLES-1. Go to ACCESS when the count reaches 0.
  - ACCESS: perform the array read or byte-enabled write. Go to RESP.
  - RESP: assert ready for one cycle. Return to IDLE.
- mRD and mWR both high in IDLE: the store wins; the load is dropped.
- Alignment rules: lh, lhu and sh require addr[0] = 0. lw and sw require addr[1:0] = 00. Byte accesses are always aligned.
- Misaligned request:
  - still traverses WAIT and ACCESS, so latency is uniform;
  - ACCESS performs no write;
  - RESP drives misalign = 1 and rdata = 0.
- Loads:
  - lb/lbu select the byte at addr[1:0];
  - lh/lhu select the half at addr[1];
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Stores:
  - sb writes wdata[7:0] into lane addr[1:0] only;
  - sh writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - sw writes all lanes;
  - unselected bytes of the word are unchanged.
- Request strobes outside IDLE are ignored. They are neither queued nor counted.

## Timing
- Reset values: rdata = 0, ready = 0, busy = 0, misalign = 0, state = IDLE, wait counter = 0.
- Memory contents are not cleared by reset.
- Request sampled at edge E0. Then:
  - ACCESS occupies the cycle after E0+WAIT_CYCLES;
  - ready, misalign and the new rdata are valid in the following cycle.
- Total latency is WAIT_CYCLES+2 cycles from the request cycle to the ready cycle.
- A store is visible to a load accepted on or after the store's ready cycle.
- The earliest back-to-back acceptance is the cycle after ready.
- rst asserted in any state:
  - next state is IDLE;
  - any pending write is discarded, unless ACCESS completes on that same edge (reset wins, so no write);
  - no ready pulse is produced.
- misalign is a pulse coincident with ready. It is 0 at all other times.

## Structure
- Shared package mem_pkg holds:
  - LOAD_LB/LBU/LH/LHU/LW (3-bit) and STORE_SB/SH/SW (2-bit) constants, also imported by the control unit;
  - the state enum for IDLE/WAIT/ACCESS/RESP.
- One sub-module, dmem_ram: a 2^ADDR_W x 32 single-port synchronous array.
  - ports: clk, en, we[3:0], word address, 32-bit din/dout;
  - read registered, one cycle.
- Lane steering, extension, alignment check and the FSM live in data_mem_unit.

## Test plan
- Word round-trip, WAIT_CYCLES=0:
  - sw 0xDEADBEEF to 0x10, then lw 0x10 -> rdata = 0xDEADBEEF;
  - ready arrives exactly 2 cycles after each request cycle.
- Byte and half extension, with word 0x10 = 0xDEADBEEF:
  - lb 0x13 -> 0xFFFFFFDE;
  - lbu 0x13 -> 0x000000DE;
  - lh 0x12 -> 0xFFFFDEAD;
  - lhu 0x10 -> 0x0000BEEF.
- Partial stores on word 0x20 = 0:
  - sb 0xAB to 0x21, then sh 0x1234 to 0x22;
  - lw 0x20 -> 0x1234AB00.
- Misalignment:
  - lw 0x12 -> ready with misalign = 1 and rdata = 0;
  - sh 0x21 -> misalign = 1, and the word is unchanged on a later lw.
- Latency and busy, WAIT_CYCLES=3:
  - lw issued in cycle 0 -> ready in cycle 5, busy high in cycles 1-5;
  - an mRD pulse in cycle 2 is ignored (only one ready).
- Reset mid-operation, WAIT_CYCLES=3:
  - sw 0x55 to 0x30, rst in cycle 2 -> no ready, outputs 0;
  - a later lw 0x30 returns the old value.
